// File: rtl/cbd_sampler_arb.sv
`default_nettype none
// ============================================================================
// Module      : cbd_sampler_arb
// Description : Round-robin arbiter that shares one CBD sampler between two
//               requesters, with a WAIT-state timeout and sampler recovery.
// Revision    : 1.0
// ============================================================================
module cbd_sampler_arb #(
  parameter int TIMEOUT = 4095,
  parameter int RST_CYC = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [1:0]   req_i,
  input  logic [511:0] seed_i,
  input  logic [1:0]   eta_i,
  output logic [1:0]   gnt_o,
  output logic [1:0]   done_o,
  output logic [1:0]   err_o,
  output logic         busy_o,
  output logic         owner_o,
  output logic         sampler_run_o,
  output logic [255:0] sampler_seed_o,
  output logic         sampler_eta_o,
  output logic         sampler_rst_n_o,
  input  logic         sampler_done_i
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_RECOVER = 2'd2
  } state_t;

  // The count reaches TIMEOUT on the edge that leaves cnt_q at TIMEOUT-1.
  localparam logic [15:0] TERM_CNT = 16'(TIMEOUT - 1);
  localparam logic [3:0]  RST_LAST = 4'(RST_CYC - 1);

  state_t         state_q, state_d;
  logic [15:0]    cnt_q, cnt_d;
  logic [3:0]     rcnt_q, rcnt_d;
  logic           last_owner_q, last_owner_d;
  logic           owner_q, owner_d;
  logic [1:0]     gnt_q, gnt_d;
  logic [1:0]     done_q, done_d;
  logic [1:0]     err_q, err_d;
  logic           busy_q, busy_d;
  logic           run_q, run_d;
  logic [255:0]   seed_q, seed_d;
  logic           eta_q, eta_d;
  logic           rst_n_q, rst_n_d;
  logic           winner;

  always_comb begin
    if (req_i == 2'b11) winner = ~last_owner_q;
    else                winner = req_i[1];
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rcnt_d       = rcnt_q;
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
    seed_d       = seed_q;
    eta_d        = eta_q;
    rst_n_d      = rst_n_q;
    gnt_d        = 2'b00;
    done_d       = 2'b00;
    err_d        = 2'b00;
    run_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        rst_n_d = 1'b1;
        // The done cycle is a mandatory idle gap before the next grant.
        if ((req_i != 2'b00) && (done_q == 2'b00)) begin
          owner_d = winner;
          seed_d  = winner ? seed_i[511:256] : seed_i[255:0];
          eta_d   = eta_i[winner];
          gnt_d   = winner ? 2'b10 : 2'b01;
          run_d   = 1'b1;
          cnt_d   = 16'd0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (sampler_done_i && !run_q) begin
          done_d       = owner_q ? 2'b10 : 2'b01;
          last_owner_d = owner_q;
          state_d      = S_IDLE;
        end else if (cnt_q == TERM_CNT) begin
          err_d        = owner_q ? 2'b10 : 2'b01;
          last_owner_d = owner_q;
          rst_n_d      = 1'b0;
          rcnt_d       = 4'd0;
          state_d      = S_RECOVER;
        end
      end

      S_RECOVER: begin
        if (!rst_n_q) begin
          if (rcnt_q == RST_LAST) rst_n_d = 1'b1;
          else                    rcnt_d  = rcnt_q + 4'd1;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= 16'd0;
      rcnt_q       <= 4'd0;
      last_owner_q <= 1'b1;
      owner_q      <= 1'b0;
      gnt_q        <= 2'b00;
      done_q       <= 2'b00;
      err_q        <= 2'b00;
      busy_q       <= 1'b0;
      run_q        <= 1'b0;
      seed_q       <= 256'd0;
      eta_q        <= 1'b0;
      rst_n_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rcnt_q       <= rcnt_d;
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      run_q        <= run_d;
      seed_q       <= seed_d;
      eta_q        <= eta_d;
      rst_n_q      <= rst_n_d;
    end
  end

  assign gnt_o           = gnt_q;
  assign done_o          = done_q;
  assign err_o           = err_q;
  assign busy_o          = busy_q;
  assign owner_o         = owner_q;
  assign sampler_run_o   = run_q;
  assign sampler_seed_o  = seed_q;
  assign sampler_eta_o   = eta_q;
  assign sampler_rst_n_o = rst_n_q;

endmodule
`default_nettype wire

// File: tb/tb_cbd_sampler_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_cbd_sampler_arb
// Description : Directed bench for cbd_sampler_arb (default and TIMEOUT=16).
// Revision    : 1.0
// ============================================================================
module tb_cbd_sampler_arb;

  localparam logic [255:0] SEED_A =
    256'h98536d1a_0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0_01234567_89abcdef_deadbeef;
  localparam logic [255:0] SEED_B =
    256'h5a5a5a5a_13579bdf_2468ace0_fedcba98_76543210_0badf00d_cafef00d_11223344;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req;
  logic [511:0] seed;
  logic [1:0]   eta;
  logic         sdone;

  logic [1:0]   d_gnt, d_done, d_err;
  logic         d_busy, d_owner, d_run, d_eta, d_rstn;
  logic [255:0] d_seed;
  logic [1:0]   t_gnt, t_done, t_err;
  logic         t_busy, t_owner, t_run, t_eta, t_rstn;
  logic [255:0] t_seed;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cbd_sampler_arb u_dut_def (
    .clk_i(clk), .rst_i(rst), .req_i(req), .seed_i(seed), .eta_i(eta),
    .gnt_o(d_gnt), .done_o(d_done), .err_o(d_err), .busy_o(d_busy),
    .owner_o(d_owner), .sampler_run_o(d_run), .sampler_seed_o(d_seed),
    .sampler_eta_o(d_eta), .sampler_rst_n_o(d_rstn), .sampler_done_i(sdone)
  );

  cbd_sampler_arb #(.TIMEOUT(16), .RST_CYC(4)) u_dut_t16 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .seed_i(seed), .eta_i(eta),
    .gnt_o(t_gnt), .done_o(t_done), .err_o(t_err), .busy_o(t_busy),
    .owner_o(t_owner), .sampler_run_o(t_run), .sampler_seed_o(t_seed),
    .sampler_eta_o(t_eta), .sampler_rst_n_o(t_rstn), .sampler_done_i(sdone)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse outputs: never two-hot, never high two cycles in a row.
  function automatic logic pulse_bad(input logic [1:0] g, input logic [1:0] d, input logic [1:0] e,
                                     input logic r, input logic [1:0] pg, input logic [1:0] pd,
                                     input logic [1:0] pe, input logic pr);
    return !$onehot0(g) || !$onehot0(d) || !$onehot0(e) ||
           ((g != 2'b00) && (pg != 2'b00)) || ((d != 2'b00) && (pd != 2'b00)) ||
           ((e != 2'b00) && (pe != 2'b00)) || (r && pr);
  endfunction

  logic [1:0] tpg = 2'b00, tpd = 2'b00, tpe = 2'b00, dpg = 2'b00, dpd = 2'b00, dpe = 2'b00;
  logic       tpr = 1'b0, dpr = 1'b0;

  always @(negedge clk) begin
    check("pulse_t16", {255'd0, pulse_bad(t_gnt, t_done, t_err, t_run, tpg, tpd, tpe, tpr)}, 256'd0);
    check("pulse_def", {255'd0, pulse_bad(d_gnt, d_done, d_err, d_run, dpg, dpd, dpe, dpr)}, 256'd0);
    tpg = t_gnt; tpd = t_done; tpe = t_err; tpr = t_run;
    dpg = d_gnt; dpd = d_done; dpe = d_err; dpr = d_run;
  end

  typedef struct {
    logic        rst;
    logic [1:0]  req;
    logic        done;
    logic [10:0] exp;   // {gnt, done, err, busy, owner, run, rst_n, eta}
    logic [1:0]  sidx;  // 0: zero, 1: SEED_A, 2: SEED_B
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [1:0] q, input logic d,
                     input logic [10:0] e, input logic [1:0] s);
    vec_t v;
    v.rst = r; v.req = q; v.done = d; v.exp = e; v.sidx = s;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 2'b00; sdone = 1'b0;
    repeat (2) step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [255:0] exp_seed;
    logic         saw;
    int           k;

    rst = 1'b1; req = 2'b00; sdone = 1'b0; eta = 2'b10;
    seed = {SEED_B, SEED_A};

    // Contention, early done, single request, withdrawn request (TIMEOUT=16 instance).
    add(1'b1, 2'b00, 1'b0, 11'b00_00_00_0_0_0_0_0, 2'd0);
    add(1'b1, 2'b11, 1'b0, 11'b00_00_00_0_0_0_0_0, 2'd0);
    add(1'b0, 2'b11, 1'b0, 11'b01_00_00_1_0_1_1_0, 2'd1);
    add(1'b0, 2'b11, 1'b1, 11'b00_00_00_1_0_0_1_0, 2'd1);
    add(1'b0, 2'b11, 1'b0, 11'b00_00_00_1_0_0_1_0, 2'd1);
    add(1'b0, 2'b11, 1'b1, 11'b00_01_00_0_0_0_1_0, 2'd1);
    add(1'b0, 2'b11, 1'b0, 11'b00_00_00_0_0_0_1_0, 2'd1);
    add(1'b0, 2'b11, 1'b0, 11'b10_00_00_1_1_1_1_1, 2'd2);
    add(1'b0, 2'b01, 1'b1, 11'b00_00_00_1_1_0_1_1, 2'd2);
    add(1'b0, 2'b01, 1'b1, 11'b00_10_00_0_1_0_1_1, 2'd2);
    add(1'b0, 2'b01, 1'b0, 11'b00_00_00_0_1_0_1_1, 2'd2);
    add(1'b0, 2'b01, 1'b0, 11'b01_00_00_1_0_1_1_0, 2'd1);
    add(1'b0, 2'b00, 1'b0, 11'b00_00_00_1_0_0_1_0, 2'd1);
    add(1'b0, 2'b00, 1'b1, 11'b00_01_00_0_0_0_1_0, 2'd1);
    add(1'b0, 2'b10, 1'b0, 11'b00_00_00_0_0_0_1_0, 2'd1);
    add(1'b0, 2'b00, 1'b0, 11'b00_00_00_0_0_0_1_0, 2'd1);
    add(1'b0, 2'b10, 1'b0, 11'b10_00_00_1_1_1_1_1, 2'd2);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; req = vecs[i].req; sdone = vecs[i].done;
      step();
      check($sformatf("vec%0d_ctl", i),
            {245'd0, t_gnt, t_done, t_err, t_busy, t_owner, t_run, t_rstn, t_eta},
            {245'd0, vecs[i].exp});
      exp_seed = (vecs[i].sidx == 2'd1) ? SEED_A : (vecs[i].sidx == 2'd2) ? SEED_B : 256'd0;
      check($sformatf("vec%0d_seed", i), t_seed, exp_seed);
    end

    // Single job with a 300-cycle sampler on the default instance.
    do_reset();
    eta = 2'b00; req = 2'b01;
    step();
    check("single_gnt_run", {254'd0, d_gnt, d_run}, {254'd0, 2'b01, 1'b1});
    check("single_seed", d_seed, SEED_A);
    check("single_eta", {255'd0, d_eta}, 256'd0);
    req = 2'b00; saw = 1'b0;
    repeat (299) begin
      step();
      if ((d_done != 2'b00) || (d_err != 2'b00) || !d_busy) saw = 1'b1;
    end
    check("single_wait", {255'd0, saw}, 256'd0);
    sdone = 1'b1;
    step();
    sdone = 1'b0;
    check("single_done", {254'd0, d_done}, {254'd0, 2'b01});
    check("single_idle", {255'd0, d_busy}, 256'd0);

    // Timeout with sampler recovery on the TIMEOUT=16 instance.
    do_reset();
    req = 2'b01;
    step();
    check("to_gnt", {254'd0, t_gnt}, {254'd0, 2'b01});
    req = 2'b00; k = 0;
    while ((t_err == 2'b00) && (k < 40)) begin
      step();
      k++;
    end
    check("to_latency", 256'(k), 256'd16);
    check("to_err", {254'd0, t_err}, {254'd0, 2'b01});
    req = 2'b10; k = 0; saw = 1'b0;
    while (!t_rstn && (k < 20)) begin
      if (t_gnt != 2'b00) saw = 1'b1;
      k++;
      step();
    end
    check("to_rst_low_cycles", 256'(k), 256'd4);
    check("to_recover_busy", {254'd0, t_busy, t_gnt != 2'b00}, {254'd0, 1'b1, 1'b0});
    step();
    check("to_idle", {254'd0, t_busy, saw | (t_gnt != 2'b00)}, 256'd0);
    step();
    check("to_next_gnt", {254'd0, t_gnt}, {254'd0, 2'b10});

    // done_i coincides with the terminal count.
    do_reset();
    req = 2'b01;
    step();
    check("coin_gnt", {254'd0, t_gnt}, {254'd0, 2'b01});
    req = 2'b00;
    repeat (15) step();
    sdone = 1'b1;
    step();
    sdone = 1'b0;
    check("coin_done", {254'd0, t_done}, {254'd0, 2'b01});
    check("coin_err", {254'd0, t_err}, 256'd0);
    step();
    check("coin_after", {253'd0, t_err, t_busy}, 256'd0);

    // Reset mid-WAIT: silent abort and last_owner back to 1.
    do_reset();
    req = 2'b11;
    step();
    check("mr_gnt1", {254'd0, t_gnt}, {254'd0, 2'b01});
    step();
    sdone = 1'b1;
    step();
    sdone = 1'b0;
    check("mr_done1", {254'd0, t_done}, {254'd0, 2'b01});
    k = 0;
    do begin
      step();
      k++;
    end while ((t_gnt == 2'b00) && (k < 10));
    check("mr_gnt2", {254'd0, t_gnt}, {254'd0, 2'b10});
    repeat (10) step();
    rst = 1'b1;
    step();
    check("mr_reset_ctl", {245'd0, t_gnt, t_done, t_err, t_busy, t_owner, t_run, t_rstn, t_eta}, 256'd0);
    check("mr_reset_seed", t_seed, 256'd0);
    rst = 1'b0;
    step();
    check("mr_rr_after_reset", {254'd0, t_gnt}, {254'd0, 2'b01});
    req = 2'b00;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cbd_sampler_arb.md
CBD_SAMPLER_ARB -- requirements
Module: cbd_sampler_arb

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 4095: WAIT-state cycle limit before abort, valid range 2..65535.
REQ-002 The block SHALL have parameter RST_CYC, default 4: number of cycles the sampler reset is held low during recovery, valid range 1..15.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port req_i, input, 2 bits: per-requester job request, level, held until the matching gnt_o.
REQ-006 The block SHALL have port seed_i, input, 512 bits: requester 0 seed in [255:0], requester 1 seed in [511:256].
REQ-007 The block SHALL have port eta_i, input, 2 bits: per-requester eta select, 0 = eta1, 1 = eta2.
REQ-008 The block SHALL have port gnt_o, output, 2 bits: one-hot, one-cycle grant pulse.
REQ-009 The block SHALL have port done_o, output, 2 bits: one-hot, one-cycle completion pulse to the job owner.
REQ-010 The block SHALL have port err_o, output, 2 bits: one-hot, one-cycle timeout-abort pulse to the job owner.
REQ-011 The block SHALL have port busy_o, output, 1 bit: high in every state except IDLE.
REQ-012 The block SHALL have port owner_o, output, 1 bit: index of the current or last job owner.
REQ-013 The block SHALL have port sampler_run_o, output, 1 bit: one-cycle start pulse to the shared CBD sampler.
REQ-014 The block SHALL have port sampler_seed_o, output, 256 bits: latched seed, stable from grant until the next grant.
REQ-015 The block SHALL have port sampler_eta_o, output, 1 bit: latched eta, stable from grant until the next grant.
REQ-016 The block SHALL have port sampler_rst_n_o, output, 1 bit: active-low sampler reset.
REQ-017 The block SHALL have port sampler_done_i, input, 1 bit: sampler completion indication.

Function
REQ-018 The block SHALL implement the states IDLE, WAIT and RECOVER, and all outputs SHALL be registered.
REQ-019 In IDLE, when req_i != 0 at an edge, that edge SHALL: select the winner; latch its seed and eta; set owner_o; pulse gnt_o[winner] and sampler_run_o together in the next cycle; clear the timeout counter; enter WAIT.
REQ-020 Arbitration SHALL be round-robin: with req_i = 2'b11, the winner is the requester that is not last_owner; with a single request, that requester wins.
REQ-021 last_owner SHALL update only on completion via done or err.
REQ-022 Requests seen outside IDLE SHALL be ignored; a requester dropping req_i before its grant withdraws with no effect.
REQ-023 In WAIT, sampler_done_i SHALL be ignored in the cycle sampler_run_o is high; in any later cycle it SHALL pulse done_o[owner] next cycle and return to IDLE.
REQ-024 In WAIT, the 16-bit counter SHALL increment every cycle.
REQ-025 When the counter reaches TIMEOUT with sampler_done_i low, the block SHALL pulse err_o[owner], drive sampler_rst_n_o low for exactly RST_CYC cycles, and enter RECOVER.
REQ-026 If sampler_done_i and the terminal count coincide, done SHALL take precedence and no err SHALL occur.
REQ-027 RECOVER SHALL return to IDLE on the cycle after sampler_rst_n_o returns high; requests SHALL not be granted in RECOVER.
REQ-028 Minimum spacing SHALL be: one IDLE cycle between done/err and the next gnt, i.e. grant-to-grant of at least 3 cycles beyond sampler latency.
REQ-029 gnt_o, done_o, err_o and sampler_run_o SHALL never be high for more than one consecutive cycle, and SHALL never be two-hot.

Reset
REQ-030 While rst_i is high, the block SHALL enter IDLE and hold: gnt_o=0, done_o=0, err_o=0, busy_o=0, owner_o=0, sampler_run_o=0, sampler_seed_o=0, sampler_eta_o=0, sampler_rst_n_o=0, counter=0, last_owner=1.
REQ-031 sampler_rst_n_o SHALL release high on the first edge with rst_i low.
REQ-032 Reset asserted mid-WAIT or mid-RECOVER SHALL abort the job silently, with no done or err pulse.

Verification
REQ-033 Single job: rst, then req_i=01, seed 0x98536d1a..., eta 0, sampler done 300 cycles after run -> gnt_o=01 with run; sampler_seed_o equals seed; done_o=01 one cycle after done_i; busy_o low after.
REQ-034 Contention: req_i=11 held from reset -> grants alternate 01, 10, 01; each done_o matches its gnt; never two-hot.
REQ-035 Timeout: TIMEOUT=16, sampler never signals done -> err_o pulses 16 cycles into WAIT; sampler_rst_n_o low for exactly 4 cycles; then IDLE; the next request is granted.
REQ-036 Coincidence: done_i asserted exactly at the terminal count -> done_o pulses, err_o stays 0.
REQ-037 Mid-job reset: rst_i pulsed 10 cycles into WAIT -> all outputs return to reset values; no done or err; last_owner=1.
REQ-038 Early done: sampler_done_i high during the run cycle -> ignored; job completes only on a later done_i.
